// File: rtl/stream_arb_pkg.sv
// Shared types, default constants and sizing helper for the stream arbiter.
package stream_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    localparam int unsigned N_SRC_DEF   = 4;
    localparam int unsigned DW_DEF      = 8;
    localparam int unsigned TIMEOUT_DEF = 16;

    // Width of a source index; never narrower than one bit.
    function automatic int unsigned grant_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_arb_rr.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo N_SRC.
module stream_arb_rr
    import stream_arb_pkg::*;
#(
    parameter  int unsigned N_SRC = N_SRC_DEF,
    localparam int unsigned GW    = grant_w(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [GW-1:0]    ptr,
    output logic [GW-1:0]    idx,
    output logic             found
);

    // Pick the requester with the smallest rotated distance from ptr.
    always_comb begin
        int unsigned best_d;
        int unsigned d;
        best_d = N_SRC;
        d      = 0;
        idx    = '0;
        found  = 1'b0;
        for (int unsigned j = 0; j < N_SRC; j++) begin
            d = (j + N_SRC - 32'(ptr)) % N_SRC;
            if (req[j] && (d < best_d)) begin
                best_d = d;
                idx    = GW'(j);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_arb.sv
// Packet-granular round-robin merge of N_SRC streams into one registered output.
// Optional stall watchdog enabled by defining STREAM_ARB_TIMEOUT_EN.
module stream_arb
    import stream_arb_pkg::*;
#(
    parameter  int unsigned N_SRC   = N_SRC_DEF,
    parameter  int unsigned DW      = DW_DEF,
    parameter  int unsigned TIMEOUT = TIMEOUT_DEF,
    localparam int unsigned GW      = grant_w(N_SRC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_SRC*DW-1:0] s_tdata,
    input  logic [N_SRC-1:0]    s_tvalid,
    input  logic [N_SRC-1:0]    s_tlast,
    output logic [N_SRC-1:0]    s_tready,
    output logic [DW-1:0]       m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic [GW-1:0]       grant,
    output logic                busy,
    output logic                err_timeout
);

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [DW-1:0]     m_tdata_q, m_tdata_d;
    logic              m_tlast_q, m_tlast_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              err_q, err_d;

    logic [GW-1:0]     rr_idx;
    logic              rr_found;
    logic [N_SRC-1:0]  grant_oh;
    logic              sel_valid;
    logic              sel_last;
    logic [DW-1:0]     sel_data;
    logic              slot_free;
    logic              accept;
    logic              term;
    logic              timeout_hit;

    stream_arb_rr #(.N_SRC(N_SRC)) u_rr (
        .req   (s_tvalid),
        .ptr   (ptr_q),
        .idx   (rr_idx),
        .found (rr_found)
    );

    assign slot_free = !m_tvalid_q || m_tready;

    // Route the granted source's beat; other sources' data and last are ignored.
    always_comb begin
        grant_oh  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (grant_q == GW'(i)) begin
                grant_oh[i] = 1'b1;
                sel_valid   = s_tvalid[i];
                sel_last    = s_tlast[i];
                sel_data    = s_tdata[i*DW +: DW];
            end
        end
    end

`ifdef STREAM_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign timeout_hit = (state_q == ST_XFER) && (cnt_q == CW'(TIMEOUT));

    // Count consecutive source-stall cycles in XFER; saturates at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q != ST_XFER) || accept || term)
            cnt_d = '0;
        else if (!sel_valid && !timeout_hit)
            cnt_d = cnt_q + 1'b1;
    end

    // Watchdog counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0 && (TIMEOUT != 0);
`endif

    // Next-state, grant, source handshake and output-register load.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;
        err_d      = 1'b0;
        s_tready   = '0;
        accept     = 1'b0;
        term       = 1'b0;

        if (m_tvalid_q && m_tready)
            m_tvalid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d = rr_idx;
                    ptr_d   = GW'((32'(rr_idx) + 1) % N_SRC);
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (slot_free) begin
                    if (timeout_hit) begin
                        // Forced termination beat takes the output slot instead of the source.
                        term       = 1'b1;
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = '0;
                        m_tlast_d  = 1'b1;
                        err_d      = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        s_tready = grant_oh;
                        if (sel_valid) begin
                            accept     = 1'b1;
                            m_tvalid_d = 1'b1;
                            m_tdata_d  = sel_data;
                            m_tlast_d  = sel_last;
                            if (sel_last)
                                state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            m_tvalid_q <= m_tvalid_d;
            err_q      <= err_d;
        end
    end

    assign m_tdata     = m_tdata_q;
    assign m_tlast     = m_tlast_q;
    assign m_tvalid    = m_tvalid_q;
    assign grant       = grant_q;
    assign busy        = (state_q == ST_XFER);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_stream_arb.sv
// Directed scoreboard bench for stream_arb (N_SRC=4, DW=8, TIMEOUT=16).
module tb_stream_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   s_tdata;
    logic [N-1:0]     s_tvalid;
    logic [N-1:0]     s_tlast;
    logic [N-1:0]     s_tready;
    logic [W-1:0]     m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic [1:0]       grant;
    logic             busy;
    logic             err_timeout;

    always #5 clk = ~clk;

    stream_arb #(.N_SRC(N), .DW(W), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .grant       (grant),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    int          vectors = 0;
    int          miscompares = 0;
    beat_t       exp_q[$];
    logic [1:0]  grant_log[$];
    logic [7:0]  mem_d[N][16];
    logic        mem_l[N][16];
    int          wr[N];
    int          rd[N];
    int          hs_cnt[N];
    logic [N-1:0] hs;
    int          cyc = 0;
    int          last_hs = -1;
    bit          gap_en = 0;
    bit          rdy_toggle = 0;
    int          err_cnt = 0;
    logic        prev_busy = 0;
    logic        prev_v = 0, prev_r = 0, prev_l = 0, prev_rst = 1;
    logic [7:0]  prev_d = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            if (rd[i] < wr[i]) begin
                s_tvalid[i]       = 1'b1;
                s_tdata[i*W +: W] = mem_d[i][rd[i]];
                s_tlast[i]        = mem_l[i][rd[i]];
            end else begin
                s_tvalid[i]       = 1'b0;
                s_tdata[i*W +: W] = 8'hEE;
                s_tlast[i]        = 1'b1;
            end
        end
    endtask

    task automatic add_beat(input int src, input logic [7:0] d, input logic l, input bit expect_out);
        mem_d[src][wr[src]] = d;
        mem_l[src][wr[src]] = l;
        wr[src]++;
        if (expect_out) exp_q.push_back('{last: l, data: d});
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            rd[i] = 0; wr[i] = 0; hs_cnt[i] = 0;
        end
        drive_sources();
    endtask

    function automatic bit drained();
        for (int i = 0; i < N; i++)
            if (rd[i] != wr[i]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: sample/compare at negedge, advance stimulus just after posedge.
    task automatic tick();
        beat_t b;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            hs[i] = s_tvalid[i] && s_tready[i];
            if (hs[i]) begin
                hs_cnt[i]++;
                if (gap_en && last_hs >= 0) chk("src_gap", 32'(cyc - last_hs), 32'd2);
                last_hs = cyc;
            end
        end
        if (prev_v && !prev_r && !rst && !prev_rst) begin
            chk("stall_valid", 32'(m_tvalid), 32'd1);
            chk("stall_data", 32'(m_tdata), 32'(prev_d));
            chk("stall_last", 32'(m_tlast), 32'(prev_l));
        end
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                b = exp_q.pop_front();
                chk("out_data", 32'(m_tdata), 32'(b.data));
                chk("out_last", 32'(m_tlast), 32'(b.last));
            end
        end
        if (err_timeout) err_cnt++;
        if (busy && !prev_busy) grant_log.push_back(grant);
        prev_busy = busy;
        prev_v = m_tvalid; prev_r = m_tready; prev_d = m_tdata; prev_l = m_tlast; prev_rst = rst;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++)
            if (hs[i]) rd[i]++;
        drive_sources();
        m_tready = rdy_toggle ? ~m_tready : 1'b1;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_m_tdata"}, 32'(m_tdata), 32'd0);
        chk({tag, "_m_tlast"}, 32'(m_tlast), 32'd0);
        chk({tag, "_s_tready"}, 32'(s_tready), 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err_timeout), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_sources();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_tready = 1'b1;
        prev_v = 1'b0;
        prev_rst = 1'b1;
        grant_log.delete();
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (exp_q.size() == 0) && !busy && !m_tvalid && drained();
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "stream_arb bench timed out");
    end

    initial begin
        int n;
        rst = 1'b1;
        m_tready = 1'b1;
        hs = '0;
        clear_sources();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("por");
        rst = 1'b0;

        // Two competing 3-beat packets: source 0 wins first, then source 2.
        do_reset();
        add_beat(0, 8'hA0, 1'b0, 1); add_beat(0, 8'hA1, 1'b0, 1); add_beat(0, 8'hA2, 1'b1, 1);
        add_beat(2, 8'hB0, 1'b0, 1); add_beat(2, 8'hB1, 1'b0, 1); add_beat(2, 8'hB2, 1'b1, 1);
        drive_sources();
        run_until_done("s1", 60);
        chk("s1_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            chk("s1_grant0", 32'(grant_log[0]), 32'd0);
            chk("s1_grant1", 32'(grant_log[1]), 32'd2);
        end
        chk("s1_hold_grant", 32'(grant), 32'd2);

        // All sources valid with single-beat packets: rotation and idle cycle between packets.
        do_reset();
        for (int i = 0; i < N; i++) add_beat(i, 8'(8'h40 + i), 1'b1, 0);
        for (int i = 0; i < N; i++) add_beat(i, 8'(8'h50 + i), 1'b1, 0);
        for (int i = 0; i < N; i++) exp_q.push_back('{last: 1'b1, data: 8'(8'h40 + i)});
        for (int i = 0; i < N; i++) exp_q.push_back('{last: 1'b1, data: 8'(8'h50 + i)});
        drive_sources();
        gap_en = 1; last_hs = -1;
        run_until_done("s2", 60);
        gap_en = 0;
        chk("s2_grants", 32'(grant_log.size()), 32'd8);
        if (grant_log.size() == 8) begin
            for (int i = 0; i < 5; i++) chk("s2_grant_seq", 32'(grant_log[i]), 32'(i % N));
        end

        // Downstream backpressure toggling: output must hold and not drop or duplicate.
        do_reset();
        add_beat(1, 8'h11, 1'b0, 1); add_beat(1, 8'h22, 1'b0, 1); add_beat(1, 8'h33, 1'b1, 1);
        drive_sources();
        rdy_toggle = 1;
        run_until_done("s3", 60);
        rdy_toggle = 0;
        m_tready = 1'b1;
        chk("s3_grant", 32'(grant), 32'd1);

        // Reset mid-packet, then lowest-index valid source wins.
        do_reset();
        add_beat(3, 8'h30, 1'b0, 1); add_beat(3, 8'h31, 1'b0, 0);
        add_beat(3, 8'h32, 1'b0, 0); add_beat(3, 8'h33, 1'b1, 0);
        drive_sources();
        n = 0;
        while (hs_cnt[3] < 2 && n < 30) begin tick(); n++; end
        chk("s4_wait", 32'(hs_cnt[3]), 32'd2);
        chk("s4_inflight_v", 32'(m_tvalid), 32'd1);
        chk("s4_inflight_d", 32'(m_tdata), 32'h31);
        chk("s4_sb_empty", 32'(exp_q.size()), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outs("s4_rst");
        do_reset();
        add_beat(3, 8'h51, 1'b1, 0);
        add_beat(1, 8'h41, 1'b1, 1);
        exp_q.push_back('{last: 1'b1, data: 8'h51});
        drive_sources();
        run_until_done("s4", 40);
        chk("s4_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            chk("s4_grant0", 32'(grant_log[0]), 32'd1);
            chk("s4_grant1", 32'(grant_log[1]), 32'd3);
        end

        // Source stalls mid-packet after one beat.
        do_reset();
        err_cnt = 0;
        add_beat(0, 8'h77, 1'b0, 1);
        drive_sources();
`ifdef STREAM_ARB_TIMEOUT_EN
        exp_q.push_back('{last: 1'b1, data: 8'h00});
        run_until_done("s5", 40);
        chk("s5_err_pulses", 32'(err_cnt), 32'd1);
`else
        repeat (25) tick();
        chk("s5_busy", 32'(busy), 32'd1);
        chk("s5_err_pulses", 32'(err_cnt), 32'd0);
        chk("s5_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("s5_m_tvalid", 32'(m_tvalid), 32'd0);
`endif
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_arb.md
STREAM_ARB -- requirements
Module: stream_arb

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of byte-stream sources (2..8).
REQ-002 SHALL have parameter DW, default 8, data width per beat.
REQ-003 SHALL have parameter TIMEOUT, default 16, stall cycles before forced packet termination (used only with STREAM_ARB_TIMEOUT_EN).
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_tdata  in  N_SRC*DW  source data; source i occupies bits [i*DW +: DW].
- s_tvalid  in  N_SRC  per-source beat valid.
- s_tlast  in  N_SRC  per-source last beat of packet.
- s_tready  out  N_SRC  per-source beat accept.
- m_tdata  out  DW  merged output data.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  output last beat.
- grant  out  clog2(N_SRC)  index of the current or last granted source.
- busy  out  1  high while a packet is in progress.
- err_timeout  out  1  one-cycle pulse on forced termination.

Function
REQ-005 SHALL arbitrate at packet granularity: once granted, a source keeps the output until its beat with s_tlast=1 is accepted.
REQ-006 SHALL use round-robin arbitration: search starts at (last grant + 1) mod N_SRC and picks the first source with s_tvalid=1.
REQ-007 SHALL implement FSM IDLE -> XFER -> IDLE:
- IDLE: if any s_tvalid=1, register grant, set busy=1, go to XFER next cycle.
- XFER: transfer beats; on acceptance of a beat with s_tlast=1, go to IDLE with busy=0.
REQ-008 SHALL assert s_tready[i] only when state=XFER, grant=i, and (m_tvalid=0 or m_tready=1); all other s_tready bits SHALL be 0.
REQ-009 SHALL register the output: a beat accepted from a source in cycle n SHALL appear on m_* in cycle n+1, giving one-cycle latency.
REQ-010 SHALL sustain one beat per cycle during a packet while m_tready=1.
REQ-011 SHALL hold m_tdata, m_tlast and m_tvalid stable while m_tvalid=1 and m_tready=0.
REQ-012 SHALL clear m_tvalid after acceptance when no new beat is loaded in the same cycle.
REQ-013 SHALL insert exactly one idle cycle (the IDLE state) between consecutive packets on the source side.
REQ-014 SHALL hold grant at its last value in IDLE until the next arbitration.
REQ-015 SHALL handle the single-beat packet case: a packet with s_tlast=1 on its first beat produces one m_tvalid beat with m_tlast=1.
REQ-016 SHALL ignore s_tlast and s_tdata of non-granted sources.

Reset
REQ-017 SHALL, on rst=1 at any time including mid-packet, immediately drive m_tvalid=0, m_tdata=0, m_tlast=0, s_tready=0, grant=0, busy=0, err_timeout=0, state=IDLE, and discard any in-flight beat.
REQ-018 SHALL set the round-robin pointer so that source 0 has highest priority at the first arbitration after reset.

Configuration
REQ-019 SHALL implement a stall watchdog when macro STREAM_ARB_TIMEOUT_EN is defined:
- Counts consecutive XFER cycles in which the granted s_tvalid=0; resets to 0 on any accepted beat.
- When the count reaches TIMEOUT, emits one beat m_tdata=0, m_tlast=1, pulses err_timeout for one cycle, and returns to IDLE.
- Any remaining beats from that source are arbitrated as a new packet.
REQ-020 SHALL, without STREAM_ARB_TIMEOUT_EN, have no counter, tie err_timeout to 0, and wait indefinitely in XFER.

Structure
REQ-021 SHALL place the FSM state enum, default N_SRC/DW/TIMEOUT constants and the grant-width function in shared package stream_arb_pkg.
REQ-022 SHALL implement the round-robin pick (request vector and pointer in; index and found out) as sub-module stream_arb_rr.

Verification
REQ-023 SHALL cover these directed scenarios:
- Reset then sources 0 and 2 both valid with 3-beat packets, m_tready=1 -> source 0 packet output first (A0,A1,A2, m_tlast on A2), then source 2; grant 0 then 2.
- All 4 sources continuously valid with 1-beat packets -> grant sequence 0,1,2,3,0; one idle cycle between beats on each s_tready.
- Source 1 sends 0x11,0x22,0x33(last) while m_tready toggles 1,0,1,0 -> m_tdata holds during stalls; output exactly 0x11,0x22,0x33 with no loss or duplication.
- rst asserted after 2 of 4 beats of source 3 -> all outputs 0 in the same cycle; next arbitration grants lowest-index valid source.
- With STREAM_ARB_TIMEOUT_EN and TIMEOUT=16: source 0 sends 1 beat (no last) then drops s_tvalid -> after 16 cycles a beat m_tdata=0x00, m_tlast=1 appears and err_timeout pulses once; without the macro the FSM stays in XFER with busy=1.
